// File: rtl/pen_locator.sv
// Light-pen locator: sweeps the 8x8 matrix pixel by pixel and reports where the pen sees light.
// Define PEN_BEST_EN to scan all 64 pixels and report the brightest hit instead of the first.
module pen_locator #(
  parameter int unsigned SETTLE_CYCLES = 2500,
  parameter int unsigned DWELL_CYCLES  = 2500,
  parameter int unsigned HIT_THRESH    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pen_in,
  output logic [7:0] row_scan,
  output logic [7:0] col_scan,
  output logic       busy,
  output logic       valid,
  output logic       found,
  output logic [2:0] row_d,
  output logic [2:0] col_d
);

  localparam int unsigned MaxCycles = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES
                                                                     : DWELL_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast  = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] DwellMax   = CntW'(DWELL_CYCLES);
  localparam logic [CntW:0]   ThreshW    = (CntW + 1)'(HIT_THRESH);

  typedef enum logic [2:0] {StIdle, StSettle, StSample, StEval, StDone} state_e;

  state_e          state_q;
  logic [5:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] hits_q;
  logic            pen_meta_q;
  logic            pen_sync_q;

  logic            hit_ok;
  logic [5:0]      next_idx;

`ifdef PEN_BEST_EN
  logic [CntW-1:0] best_hits_q;
  logic [5:0]      best_idx_q;
  logic            best_ok_q;
  logic            best_take;
`endif

  always_comb begin
    hit_ok   = {1'b0, hits_q} >= ThreshW;
    next_idx = idx_q + 6'd1;
`ifdef PEN_BEST_EN
    // Strictly greater keeps the earlier pixel on ties.
    best_take = hit_ok && (!best_ok_q || (hits_q > best_hits_q));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      hits_q      <= '0;
      pen_meta_q  <= 1'b0;
      pen_sync_q  <= 1'b0;
      row_scan    <= 8'hFF;
      col_scan    <= 8'h00;
      busy        <= 1'b0;
      valid       <= 1'b0;
      found       <= 1'b0;
      row_d       <= '0;
      col_d       <= '0;
`ifdef PEN_BEST_EN
      best_hits_q <= '0;
      best_idx_q  <= '0;
      best_ok_q   <= 1'b0;
`endif
    end else begin
      pen_meta_q <= pen_in;
      pen_sync_q <= pen_meta_q;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StSettle;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b1;
            row_scan    <= 8'hFE;
            col_scan    <= 8'h01;
`ifdef PEN_BEST_EN
            best_hits_q <= '0;
            best_idx_q  <= '0;
            best_ok_q   <= 1'b0;
`endif
          end
        end

        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_q <= StSample;
            cnt_q   <= '0;
            hits_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StSample: begin
          if (pen_sync_q && (hits_q != DwellMax)) begin
            hits_q <= hits_q + 1'b1;
          end
          if (cnt_q == DwellLast) begin
            state_q <= StEval;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StEval: begin
`ifdef PEN_BEST_EN
          if (best_take) begin
            best_ok_q   <= 1'b1;
            best_hits_q <= hits_q;
            best_idx_q  <= idx_q;
          end
          if (idx_q == 6'd63) begin
            state_q  <= StDone;
            valid    <= 1'b1;
            row_scan <= 8'hFF;
            col_scan <= 8'h00;
            found    <= best_ok_q || best_take;
            if (best_take) begin
              row_d <= idx_q[5:3];
              col_d <= idx_q[2:0];
            end else if (best_ok_q) begin
              row_d <= best_idx_q[5:3];
              col_d <= best_idx_q[2:0];
            end
          end else begin
            state_q  <= StSettle;
            idx_q    <= next_idx;
            row_scan <= ~(8'd1 << next_idx[5:3]);
            col_scan <= 8'd1 << next_idx[2:0];
          end
`else
          if (hit_ok || (idx_q == 6'd63)) begin
            state_q  <= StDone;
            valid    <= 1'b1;
            row_scan <= 8'hFF;
            col_scan <= 8'h00;
            found    <= hit_ok;
            if (hit_ok) begin
              row_d <= idx_q[5:3];
              col_d <= idx_q[2:0];
            end
          end else begin
            state_q  <= StSettle;
            idx_q    <= next_idx;
            row_scan <= ~(8'd1 << next_idx[5:3]);
            col_scan <= 8'd1 << next_idx[2:0];
          end
`endif
        end

        StDone: begin
          // start is deliberately not looked at here.
          state_q <= StIdle;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
